// File: rtl/acc_cpu_core.sv
// acc_cpu_core: multicycle accumulator CPU with one shared req/ack memory.
// Ports: clk, reset (async, active-low); mem_req/mem_we/mem_addr/mem_wdata
// out, mem_rdata/mem_ack in; pc/acc/halted/illegal debug outputs.
// Option ACC_CPU_CARRY_EN adds a carry flag output and the JC opcode (9).
module acc_cpu_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int OP_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              halted,
  output logic              illegal
`ifdef ACC_CPU_CARRY_EN
  ,
  output logic              carry
`endif
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC_RD, S_EXEC_WR, S_HALT
  } state_e;

  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ST   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LD   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JMP  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_JZ   = OP_W'(8);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;

  logic [OP_W-1:0]   op;
  logic [ADDR_W-1:0] opd;
  logic is_nop, is_halt, is_add, is_st, is_ld;
  logic is_jmp, is_sub, is_jz;

  assign op      = ir_q[DATA_W-1 -: OP_W];
  assign opd     = ir_q[ADDR_W-1:0];
  assign is_nop  = (op == OP_NOP);
  assign is_halt = (op == OP_HALT);
  assign is_add  = (op == OP_ADD);
  assign is_st   = (op == OP_ST);
  assign is_ld   = (op == OP_LD);
  assign is_jmp  = (op == OP_JMP);
  assign is_sub  = (op == OP_SUB);
  assign is_jz   = (op == OP_JZ);

`ifdef ACC_CPU_CARRY_EN
  localparam logic [OP_W-1:0] OP_JC = OP_W'(9);
  logic              carry_q, carry_d;
  logic              is_jc;
  logic [DATA_W:0]   add_w, sub_w;
  assign is_jc = (op == OP_JC);
  // Top bit is the carry-out for add and the borrow for subtract.
  assign add_w = {1'b0, acc_q} + {1'b0, mem_rdata};
  assign sub_w = {1'b0, acc_q} - {1'b0, mem_rdata};
  assign carry = carry_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      acc_q     <= '0;
      ir_q      <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ACC_CPU_CARRY_EN
      carry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      acc_q     <= acc_d;
      ir_q      <= ir_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
`ifdef ACC_CPU_CARRY_EN
      carry_q   <= carry_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    ir_d      = ir_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
`ifdef ACC_CPU_CARRY_EN
    carry_d   = carry_q;
`endif
    unique case (state_q)
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_FETCH;
        unique case (1'b1)
          is_nop: ;
          is_halt: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          is_add, is_ld, is_sub: state_d = S_EXEC_RD;
          is_st:  state_d = S_EXEC_WR;
          is_jmp: pc_d = opd;
          is_jz: begin
            if (acc_q == '0) pc_d = opd;
          end
`ifdef ACC_CPU_CARRY_EN
          is_jc: begin
            if (carry_q) pc_d = opd;
          end
`endif
          default: illegal_d = 1'b1;
        endcase
      end
      S_EXEC_RD: begin
        if (mem_ack) begin
          unique case (1'b1)
`ifdef ACC_CPU_CARRY_EN
            is_add: begin
              acc_d   = add_w[DATA_W-1:0];
              carry_d = add_w[DATA_W];
            end
            is_sub: begin
              acc_d   = sub_w[DATA_W-1:0];
              carry_d = sub_w[DATA_W];
            end
`else
            is_add: acc_d = acc_q + mem_rdata;
            is_sub: acc_d = acc_q - mem_rdata;
`endif
            default: acc_d = mem_rdata;
          endcase
          state_d = S_FETCH;
        end
      end
      S_EXEC_WR: begin
        if (mem_ack) state_d = S_FETCH;
      end
      default: ;
    endcase
  end

  // Gated by reset so the bus drops the instant reset asserts,
  // even though the state register already reads FETCH.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset) begin
      mem_wdata = acc_q;
      unique case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_addr = pc_q;
        end
        S_EXEC_RD: begin
          mem_req  = 1'b1;
          mem_addr = opd;
        end
        S_EXEC_WR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          mem_addr = opd;
        end
        default: ;
      endcase
    end
  end

  assign pc      = pc_q;
  assign acc     = acc_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// tb_acc_cpu_core: directed and random programs against an ISA-level model.
// Memory responder inserts fixed or random wait states.
module tb_acc_cpu_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we, mem_ack;
  logic [7:0]  mem_addr, pc;
  logic [15:0] mem_wdata, mem_rdata, acc;
  logic        halted, illegal;
`ifdef ACC_CPU_CARRY_EN
  logic        carry;
`endif

  always #5 clk = ~clk;

  acc_cpu_core dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .pc        (pc),
    .acc       (acc),
    .halted    (halted),
    .illegal   (illegal)
`ifdef ACC_CPU_CARRY_EN
    ,
    .carry     (carry)
`endif
  );

  logic [15:0] img [256];
  logic [15:0] dmem [256];
  logic [15:0] mm [256];
  logic [24:0] dtrace [$];
  logic [24:0] mtrace [$];

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  int  wmode = 0;
  bit  hold = 1'b0;
  int  wcnt, tgt, waits, unstable;
  logic [24:0] prev;
  bit  prev_v;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int draw();
    return (wmode < 0) ? int'($urandom_range(0, 3)) : wmode;
  endfunction

  assign mem_ack   = mem_req && !hold && (wcnt >= tgt);
  assign mem_rdata = dmem[mem_addr];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) dmem[i] <= img[i];
      dtrace.delete();
      wcnt <= 0;
      tgt <= draw();
      waits <= 0;
      unstable <= 0;
      prev_v <= 1'b0;
    end else if (mem_req) begin
      if (prev_v && prev !== {mem_we, mem_addr, mem_wdata})
        unstable <= unstable + 1;
      if (mem_ack) begin
        if (mem_we) dmem[mem_addr] <= mem_wdata;
        dtrace.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 16'h0});
        wcnt <= 0;
        tgt <= draw();
        prev_v <= 1'b0;
      end else begin
        waits <= waits + 1;
        wcnt <= wcnt + 1;
        prev <= {mem_we, mem_addr, mem_wdata};
        prev_v <= 1'b1;
      end
    end else begin
      prev_v <= 1'b0;
    end
  end

  // Instruction-level reference: one loop iteration per instruction.
  task automatic model_run(output logic [15:0] m_acc, output logic [7:0] m_pc,
                           output bit m_halt, output bit m_ill,
                           output bit m_c, output int m_cyc);
    logic [15:0] a, ir, d;
    logic [7:0]  p, o;
    logic [16:0] w;
    bit h, il, c;
    int cy;
    a = 0; p = 0; h = 0; il = 0; c = 0; cy = 0;
    mtrace.delete();
    for (int i = 0; i < 256; i++) mm[i] = img[i];
    for (int n = 0; n < 400 && !h; n++) begin
      ir = mm[p];
      mtrace.push_back({1'b0, p, 16'h0});
      p = p + 8'd1;
      o = ir[7:0];
      d = mm[o];
      cy += 2;
      case (ir[15:8])
        8'd0: ;
        8'd1: h = 1;
        8'd3: begin
          mtrace.push_back({1'b0, o, 16'h0});
          w = {1'b0, a} + {1'b0, d};
          a = w[15:0]; c = w[16]; cy++;
        end
        8'd7: begin
          mtrace.push_back({1'b0, o, 16'h0});
          c = (a < d); a = a - d; cy++;
        end
        8'd5: begin
          mtrace.push_back({1'b0, o, 16'h0});
          a = d; cy++;
        end
        8'd4: begin
          mtrace.push_back({1'b1, o, a});
          mm[o] = a; cy++;
        end
        8'd6: p = o;
        8'd8: if (a == 0) p = o;
`ifdef ACC_CPU_CARRY_EN
        8'd9: if (c) p = o;
`endif
        default: il = 1;
      endcase
    end
    m_acc = a; m_pc = p; m_halt = h; m_ill = il; m_c = c; m_cyc = cy;
  endtask

  task automatic run(input string nm, input int wm, output int cyc);
    logic [15:0] m_acc;
    logic [7:0]  m_pc;
    bit m_halt, m_ill, m_c;
    int m_cyc, bad;
    wmode = wm;
    hold = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    while (!halted && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    model_run(m_acc, m_pc, m_halt, m_ill, m_c, m_cyc);
    chk({nm, "/halted"}, 32'(halted), 32'(m_halt));
    chk({nm, "/acc"}, 32'(acc), 32'(m_acc));
    chk({nm, "/pc"}, 32'(pc), 32'(m_pc));
    chk({nm, "/illegal"}, 32'(illegal), 32'(m_ill));
`ifdef ACC_CPU_CARRY_EN
    chk({nm, "/carry"}, 32'(carry), 32'(m_c));
`endif
    chk({nm, "/cycles"}, 32'(cyc), 32'(m_cyc + waits));
    bad = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== mm[i]) bad++;
    chk({nm, "/memory"}, 32'(bad), 32'd0);
    bad = (dtrace.size() != mtrace.size()) ? 1 : 0;
    for (int i = 0; i < dtrace.size() && i < mtrace.size(); i++)
      if (dtrace[i] !== mtrace[i]) bad++;
    chk({nm, "/trace"}, 32'(bad), 32'd0);
    chk({nm, "/stable"}, 32'(unstable), 32'd0);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 16'h0000;
  endtask

  task automatic prog_basic();
    clear_img();
    img[0] = 16'h0510; img[1] = 16'h0311;
    img[2] = 16'h0412; img[3] = 16'h0100;
    img[8'h10] = 16'h1234; img[8'h11] = 16'h0101;
  endtask

  task automatic prog_random();
    int ops [12] = '{0, 3, 3, 4, 5, 5, 6, 7, 7, 8, 9, 10};
    int op, o;
    for (int i = 0; i < 256; i++) img[i] = 16'($urandom);
    for (int i = 28; i < 128; i++) img[i] = 16'h0100;
    for (int i = 0; i < 28; i++) begin
      op = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 15) == 0) op = 1;
      if (op == 6 || op == 8 || op == 9) o = $urandom_range(i + 1, 31);
      else if (op == 4) o = $urandom_range(128, 255);
      else o = $urandom_range(0, 255);
      img[i] = {8'(op), 8'(o)};
    end
  endtask

  int cyc;

  initial begin
    // Reset state and a request abandoned mid-transfer.
    prog_basic();
    hold = 1'b1;
    wmode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/req", 32'(mem_req), 32'd0);
    chk("rst/pc", 32'(pc), 32'd0);
    chk("rst/acc", 32'(acc), 32'd0);
    chk("rst/halted", 32'(halted), 32'd0);
    chk("rst/illegal", 32'(illegal), 32'd0);
    reset = 1'b1;
    #1;
    chk("first/req", 32'(mem_req), 32'd1);
    chk("first/addr", 32'(mem_addr), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("held/req", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort/req", 32'(mem_req), 32'd0);
    chk("abort/we", 32'(mem_we), 32'd0);
    chk("abort/addr", 32'(mem_addr), 32'd0);
    chk("abort/wdata", 32'(mem_wdata), 32'd0);
    hold = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("restart/req", 32'(mem_req), 32'd1);
    chk("restart/we", 32'(mem_we), 32'd0);
    chk("restart/addr", 32'(mem_addr), 32'd0);

    prog_basic();
    run("basic0", 0, cyc);
    chk("basic0/m12", 32'(dmem[8'h12]), 32'h1335);
    chk("basic0/acc", 32'(acc), 32'h1335);
    chk("basic0/pc", 32'(pc), 32'd4);
    chk("basic0/lat", 32'(cyc), 32'd11);
    run("basic3", 3, cyc);
    chk("basic3/m12", 32'(dmem[8'h12]), 32'h1335);
    chk("basic3/lat", 32'(cyc), 32'd32);

    clear_img();
    img[0] = 16'h0820; img[1] = 16'h0100; img[8'h20] = 16'h0100;
    run("jz_take", 0, cyc);
    chk("jz_take/pc", 32'(pc), 32'h21);

    clear_img();
    img[0] = 16'h0540; img[1] = 16'h0820; img[2] = 16'h0100;
    img[8'h20] = 16'h0100; img[8'h40] = 16'h0005;
    run("jz_skip", 1, cyc);
    chk("jz_skip/pc", 32'(pc), 32'd3);

    // Reach 0xFF, ADD wraps acc to zero and pc to 0, where a
    // HALT was planted by an earlier STORE.
    clear_img();
    img[0] = 16'h0630;
    img[8'h30] = 16'h0521; img[8'h31] = 16'h0400;
    img[8'h32] = 16'h0520; img[8'h33] = 16'h06FF;
    img[8'hFF] = 16'h0310;
    img[8'h10] = 16'h0001; img[8'h20] = 16'hFFFF; img[8'h21] = 16'h0100;
    run("wrap", -1, cyc);
    chk("wrap/acc", 32'(acc), 32'd0);
    chk("wrap/pc", 32'(pc), 32'd1);
`ifdef ACC_CPU_CARRY_EN
    chk("wrap/carry", 32'(carry), 32'd1);
`endif

    clear_img();
    img[0] = 16'h0A00; img[1] = 16'h0900; img[2] = 16'h0100;
    run("illegal", 0, cyc);
    chk("illegal/flag", 32'(illegal), 32'd1);
    chk("illegal/pc", 32'(pc), 32'd3);

    clear_img();
    img[0] = 16'h0510; img[1] = 16'h0403; img[2] = 16'h0000;
    img[3] = 16'h0511; img[8'h10] = 16'h0100; img[8'h11] = 16'h7777;
    run("selfmod", 2, cyc);
    chk("selfmod/acc", 32'(acc), 32'h0100);

    for (int t = 0; t < 12; t++) begin
      prog_random();
      run($sformatf("rand%0d", t), -1, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
